// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO, runtime baud divisor, optional parity and one or two stop bits.
// The frame settings are latched when a byte is popped, so a frame never changes its format part-way through.
module uart_tx_fifo #(
    parameter int DataBits  = 8,
    parameter int DivWidth  = 16,
    parameter int FifoDepth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DivWidth-1:0]          cfg_div_i,
    input  logic [1:0]                   cfg_parity_i,
    input  logic                         cfg_stop2_i,
    input  logic [DataBits-1:0]          data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         tx_o,
    output logic                         busy_o,
    output logic [$clog2(FifoDepth):0]   level_o
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int LvlW = PtrW + 1;
    localparam int BitW = $clog2(DataBits);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [DataBits-1:0] mem [FifoDepth];
    logic [PtrW-1:0]     wr_ptr_reg;
    logic [PtrW-1:0]     rd_ptr_reg;
    logic [LvlW-1:0]     level_reg;
    logic [DataBits-1:0] head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    assign fifo_full  = (level_reg == LvlW'(FifoDepth));
    assign fifo_empty = (level_reg == '0);
    assign ready_o    = !rst_i && !fifo_full;
    assign push       = valid_i && ready_o;
    assign head       = mem[rd_ptr_reg];
    assign level_o    = level_reg;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    // Pointer widths equal log2(depth), so increment wraps modulo depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LvlW'(1);
                2'b01:   level_reg <= level_reg - LvlW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t              state_reg;
    logic                tx_reg;
    logic                busy_reg;
    logic [DivWidth-1:0] baud_cnt_reg;
    logic [DivWidth-1:0] div_reg;
    logic [BitW-1:0]     bit_cnt_reg;
    logic [DataBits-1:0] shift_reg;
    logic [DataBits-1:0] data_reg;
    logic [1:0]          parity_reg;
    logic                stop2_reg;
    logic                stop_half_reg;

    logic [DivWidth-1:0] div_eff;
    logic                baud_last;
    logic                bit_last;
    logic                stop_last;
    logic                parity_en;
    logic                parity_bit;

    assign div_eff    = (cfg_div_i <= DivWidth'(1)) ? DivWidth'(1) : cfg_div_i;
    assign baud_last  = (baud_cnt_reg == div_reg - DivWidth'(1));
    assign bit_last   = (bit_cnt_reg == BitW'(DataBits - 1));
    assign stop_last  = baud_last && (!stop2_reg || stop_half_reg);
    assign parity_en  = (parity_reg == 2'b01) || (parity_reg == 2'b10);
    assign parity_bit = (^data_reg) ^ (parity_reg == 2'b10);

    // A pop happens from Idle or on the final stop cycle, giving gapless back-to-back frames.
    assign pop = !fifo_empty &&
                 ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && stop_last));

    assign tx_o   = tx_reg;
    assign busy_o = busy_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            tx_reg        <= 1'b1;
            busy_reg      <= 1'b0;
            baud_cnt_reg  <= '0;
            div_reg       <= DivWidth'(1);
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            parity_reg    <= 2'b00;
            stop2_reg     <= 1'b0;
            stop_half_reg <= 1'b0;
        end else if (pop) begin
            state_reg     <= ST_START;
            tx_reg        <= 1'b0;
            busy_reg      <= 1'b1;
            baud_cnt_reg  <= '0;
            div_reg       <= div_eff;
            bit_cnt_reg   <= '0;
            shift_reg     <= head;
            data_reg      <= head;
            parity_reg    <= cfg_parity_i;
            stop2_reg     <= cfg_stop2_i;
            stop_half_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                end
                ST_START: begin
                    if (baud_last) begin
                        state_reg    <= ST_DATA;
                        tx_reg       <= shift_reg[0];
                        baud_cnt_reg <= '0;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + DivWidth'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        if (bit_last) begin
                            if (parity_en) begin
                                state_reg <= ST_PARITY;
                                tx_reg    <= parity_bit;
                            end else begin
                                state_reg     <= ST_STOP;
                                tx_reg        <= 1'b1;
                                stop_half_reg <= 1'b0;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BitW'(1);
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + DivWidth'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_last) begin
                        state_reg     <= ST_STOP;
                        tx_reg        <= 1'b1;
                        baud_cnt_reg  <= '0;
                        stop_half_reg <= 1'b0;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + DivWidth'(1);
                    end
                end
                ST_STOP: begin
                    if (stop_last) begin
                        state_reg    <= ST_IDLE;
                        tx_reg       <= 1'b1;
                        busy_reg     <= 1'b0;
                        baud_cnt_reg <= '0;
                    end else if (baud_last) begin
                        baud_cnt_reg  <= '0;
                        stop_half_reg <= 1'b1;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + DivWidth'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: every serial frame is compared cycle by cycle against hand-built bit patterns.
module tb_uart_tx_fifo;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] cfg_div_i;
    logic [1:0]  cfg_parity_i;
    logic        cfg_stop2_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic        tx_o;
    logic        busy_o;
    logic [2:0]  level_o;

    int errors = 0;
    int checks = 0;

    uart_tx_fifo #(
        .DataBits  (8),
        .DivWidth  (16),
        .FifoDepth (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cfg_div_i    (cfg_div_i),
        .cfg_parity_i (cfg_parity_i),
        .cfg_stop2_i  (cfg_stop2_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .level_o      (level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Entered just after the edge that started the frame; leaves just after the edge that ended it.
    task automatic check_frame(input logic [11:0] bits, input int n, input int d, input string name);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < d; c++) begin
                checks++;
                if (tx_o !== bits[i]) begin
                    $display("FAIL %s tx bit%0d cyc%0d: got %b expected %b", name, i, c, tx_o, bits[i]);
                    errors++;
                end
                checks++;
                if (busy_o !== 1'b1) begin
                    $display("FAIL %s busy bit%0d cyc%0d: got %b expected 1", name, i, c, busy_o);
                    errors++;
                end
                step();
                valid_i = 1'b0;
            end
        end
        $display("frame %s: %0d bits x %0d cycles checked", name, n, d);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (busy_o !== 1'b0 || tx_o !== 1'b1 || level_o !== 3'd0) begin
            $display("FAIL %s idle: busy=%b tx=%b level=%0d expected busy=0 tx=1 level=0",
                     name, busy_o, tx_o, level_o);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) step();
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || level_o !== 3'd0 || ready_o !== 1'b0) begin
            $display("FAIL reset_state: tx=%b busy=%b level=%0d ready=%b expected 1 0 0 0",
                     tx_o, busy_o, level_o, ready_o);
            errors++;
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            $display("FAIL reset_release_ready: got %b expected 1", ready_o);
            errors++;
        end
        step();
        $display("reset checked");
    endtask

    task automatic test_8n1();
        cfg_div_i = 16'd4; cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
        valid_i = 1'b1; data_i = 8'hA5;
        step();
        valid_i = 1'b0;
        checks++;
        if (level_o !== 3'd1 || tx_o !== 1'b1 || busy_o !== 1'b0) begin
            $display("FAIL 8n1_accept_edge: level=%0d tx=%b busy=%b expected 1 1 0", level_o, tx_o, busy_o);
            errors++;
        end
        step();
        checks++;
        if (level_o !== 3'd0) begin
            $display("FAIL 8n1_pop_level: got %0d expected 0", level_o);
            errors++;
        end
        check_frame({2'b00, 10'b1_10100101_0}, 10, 4, "8n1_A5");
        check_idle("8n1_end");
        step();
    endtask

    task automatic test_parity();
        cfg_div_i = 16'd1; cfg_parity_i = 2'b01; cfg_stop2_i = 1'b0;
        valid_i = 1'b1; data_i = 8'h07;
        step();
        valid_i = 1'b0;
        step();
        check_frame({1'b0, 11'b1_1_00000111_0}, 11, 1, "even_07");
        check_idle("even_end");
        cfg_parity_i = 2'b10;
        valid_i = 1'b1; data_i = 8'h07;
        step();
        valid_i = 1'b0;
        step();
        check_frame({1'b0, 11'b1_0_00000111_0}, 11, 1, "odd_07");
        check_idle("odd_end");
        cfg_parity_i = 2'b00;
        step();
    endtask

    task automatic test_back_to_back();
        cfg_div_i = 16'd3; cfg_parity_i = 2'b00; cfg_stop2_i = 1'b1;
        valid_i = 1'b1; data_i = 8'h00;
        step();
        data_i = 8'hFF;
        step();
        valid_i = 1'b0;
        checks++;
        if (level_o !== 3'd1) begin
            $display("FAIL b2b_queued_level: got %0d expected 1", level_o);
            errors++;
        end
        check_frame({1'b0, 11'b11_00000000_0}, 11, 3, "stop2_00");
        check_frame({1'b0, 11'b11_11111111_0}, 11, 3, "stop2_FF");
        check_idle("b2b_end");
        cfg_stop2_i = 1'b0;
        step();
    endtask

    task automatic test_fifo_full();
        int wait_cnt;
        cfg_div_i = 16'd2; cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
        valid_i = 1'b1;
        for (int b = 0; b < 5; b++) begin
            data_i = 8'h10 + 8'(b);
            step();
        end
        data_i = 8'h15;
        checks++;
        if (level_o !== 3'd4 || ready_o !== 1'b0) begin
            $display("FAIL full_level_ready: level=%0d ready=%b expected 4 0", level_o, ready_o);
            errors++;
        end
        wait_cnt = 0;
        while (ready_o !== 1'b1 && wait_cnt < 40) begin
            step();
            wait_cnt++;
        end
        checks++;
        if (wait_cnt != 17) begin
            $display("FAIL full_ready_rise: got %0d cycles expected 17", wait_cnt);
            errors++;
        end
        checks++;
        if (level_o !== 3'd3) begin
            $display("FAIL full_after_pop_level: got %0d expected 3", level_o);
            errors++;
        end
        check_frame({2'b00, 10'b1_00010001_0}, 10, 2, "fifo_11");
        checks++;
        if (level_o !== 3'd3) begin
            $display("FAIL full_refill_level: got %0d expected 3", level_o);
            errors++;
        end
        check_frame({2'b00, 10'b1_00010010_0}, 10, 2, "fifo_12");
        check_frame({2'b00, 10'b1_00010011_0}, 10, 2, "fifo_13");
        check_frame({2'b00, 10'b1_00010100_0}, 10, 2, "fifo_14");
        check_frame({2'b00, 10'b1_00010101_0}, 10, 2, "fifo_15");
        check_idle("fifo_end");
        step();
    endtask

    task automatic test_div_change();
        cfg_div_i = 16'd4; cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
        valid_i = 1'b1; data_i = 8'h3C;
        step();
        data_i = 8'hC3;
        step();
        valid_i = 1'b0;
        cfg_div_i = 16'd2;
        check_frame({2'b00, 10'b1_00111100_0}, 10, 4, "div4_3C");
        check_frame({2'b00, 10'b1_11000011_0}, 10, 2, "div2_C3");
        check_idle("div_end");
        cfg_div_i = 16'd0;
        valid_i = 1'b1; data_i = 8'h55;
        step();
        valid_i = 1'b0;
        step();
        check_frame({2'b00, 10'b1_01010101_0}, 10, 1, "div0_55");
        check_idle("div0_end");
        step();
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        cfg_div_i = 16'd4; cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
        valid_i = 1'b1; data_i = 8'h81;
        step();
        data_i = 8'h82;
        step();
        data_i = 8'h83;
        step();
        valid_i = 1'b0;
        repeat (8) step();
        checks++;
        if (level_o !== 3'd2 || busy_o !== 1'b1) begin
            $display("FAIL mid_pre_reset: level=%0d busy=%b expected 2 1", level_o, busy_o);
            errors++;
        end
        rst_i = 1'b1;
        step();
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || level_o !== 3'd0 || ready_o !== 1'b0) begin
            $display("FAIL mid_reset_state: tx=%b busy=%b level=%0d ready=%b expected 1 0 0 0",
                     tx_o, busy_o, level_o, ready_o);
            errors++;
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            $display("FAIL mid_release_ready: got %b expected 1", ready_o);
            errors++;
        end
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || level_o !== 3'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL mid_no_more_frames: %0d non-idle cycles expected 0", bad);
            errors++;
        end
        $display("reset mid-frame checked");
    endtask

    initial begin
        rst_i        = 1'b1;
        cfg_div_i    = 16'd1;
        cfg_parity_i = 2'b00;
        cfg_stop2_i  = 1'b0;
        data_i       = 8'h00;
        valid_i      = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_fifo_full();
        test_div_change();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Adds a valid/ready input, a small transmit FIFO, runtime baud divisor, selectable data width, parity and stop-bit count. Sits between a bus-side register block and the `tx` pad, one instance per serial channel.

## Interface

- `DataBits`, default 8: frame data width; legal 5..9.
- `DivWidth`, default 16: width of the baud divisor.
- `FifoDepth`, default 4: FIFO entries; power of two, ≥ 2.

- `clk_i`  input  1  sole clock.
- `rst_i`  input  1  reset, synchronous, active-high.
- `cfg_div_i`  input  DivWidth  clock cycles per bit (D); values 0 and 1 both mean D=1.
- `cfg_parity_i`  input  2  00 none, 01 even, 10 odd, 11 reserved (= none).
- `cfg_stop2_i`  input  1  0: one stop bit, 1: two stop bits.
- `data_i`  input  DataBits  byte to send.
- `valid_i`  input  1  `data_i` offered.
- `ready_o`  output  1  FIFO can accept; push when `valid_i && ready_o`.
- `tx_o`  output  1  serial line, idle high, registered.
- `busy_o`  output  1  frame in progress (FSM not Idle).
- `level_o`  output  $clog2(FifoDepth)+1  FIFO occupancy.

## Operation

- Reset: `tx_o`=1, `busy_o`=0, `level_o`=0, FIFO flushed, FSM Idle. `ready_o`=0 while `rst_i`=1, otherwise `ready_o` = !full.
- FIFO: push on `valid_i && ready_o`; pop only by FSM. Simultaneous push and pop on non-empty, non-full FIFO: level unchanged. When full, a same-cycle pop does not enable a push (ready from current level). Pointers wrap modulo FifoDepth.
- FSM states: Idle, Start, Data, Parity, Stop.
  - Idle: if FIFO non-empty, pop head into shifter, latch D, parity mode and stop count, go Start.
  - Start: `tx_o`=0 for D cycles → Data.
  - Data: DataBits bits, LSB first, each D cycles → Parity if parity enabled, else Stop.
  - Parity: even = XOR of data bits; odd = its inverse; D cycles → Stop.
  - Stop: `tx_o`=1 for D (one stop) or 2·D (two stop) cycles. At the last stop cycle: if FIFO non-empty, pop and go directly to Start (no idle gap); else Idle.
- Configuration inputs are sampled only at pop; changes mid-frame affect the next frame only.
- Bit counter counts 0..DataBits-1; baud counter counts 0..D-1 and restarts at every bit boundary.
- Reset mid-frame: on the reset edge `tx_o` returns high, the frame is truncated, FIFO contents are discarded.

## Timing

- Push accepted at edge k into an empty FIFO with FSM Idle: `level_o`=1 after edge k; pop and `tx_o` falling after edge k+1; `busy_o` high from the same edge.
- Frame length = D·(1 + DataBits + P + S) cycles, where P∈{0,1} and S∈{1,2}.
- Back-to-back frames: the next start bit follows the last stop cycle with zero gap.
- `busy_o` falls on the edge where Stop ends with the FIFO empty; `tx_o` remains 1.
- `ready_o` is combinational from level and `rst_i`; there is no other input-to-output combinational path.

## Test plan

- D=4, 8N1, push 0xA5 into idle block → `tx_o` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; start bit falls 1 cycle after the accepting edge; `busy_o` high for 40 cycles.
- D=1, even parity, push 0x07 → parity bit 1; odd parity → parity bit 0; frame length 11 cycles.
- Two stop bits, D=3, push 0x00 and 0xFF back-to-back → stop high for 6 cycles, then the next start bit with no gap.
- FifoDepth=4, hold `valid_i`=1 during a frame → `ready_o` drops after 4 accepts (`level_o`=4); rises the cycle after the next pop; all bytes are transmitted in order.
- `cfg_div_i` changed from 4 to 2 mid-frame → current frame keeps D=4; next frame uses D=2; `cfg_div_i`=0 behaves as D=1.
- `rst_i` pulsed during Data with 2 bytes queued → `tx_o`=1, `busy_o`=0, `level_o`=0 after the reset edge; no further frames are sent.
